// File: rtl/gray_pkg.sv
// Shared types and Gray/binary conversion helpers for the Gray burst controller.
package gray_pkg;

    // Widest Gray code the helpers handle; callers zero-extend narrower
    // values in and size-cast the result back to their own width.
    localparam int GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gb_state_t;

    // Binary to reflected Gray: each Gray bit is the XOR of adjacent binary bits.
    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: prefix XOR running down from the MSB. Zero-extended
    // upper bits contribute nothing, so one wide routine serves every width.
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_core.sv
// Gray-code counter datapath: a binary register stepped up or down by one,
// with its value presented as a Gray code.
module gray_core
    import gray_pkg::*;
#(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         en,
    input  logic         down,
    output logic [N-1:0] g
);

    logic [N-1:0] bin;

    // Binary counter: load has priority over stepping; wraps modulo 2^N.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of block ordering.
        if (rst) begin
            bin <= '0;
        end else if (load) begin
            bin <= load_val;
        end else if (en) begin
            bin <= down ? bin - N'(1) : bin + N'(1);
        end
    end

    assign g = N'(bin2gray(gray_word_t'(bin)));

endmodule

// File: rtl/gray_burst_ctrl.sv
// Command-driven burst sequencer: accepts a (start, length, direction) command,
// then streams that many consecutive Gray codes over a valid/ready interface.
module gray_burst_ctrl
    import gray_pkg::*;
#(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [N-1:0] cmd_start,
    input  logic [N-1:0] cmd_len,
    input  logic         cmd_down,
    input  logic         abort,
    output logic         g_valid,
    input  logic         g_ready,
    output logic [N-1:0] g_code,
    output logic         g_last,
    output logic         busy,
    output logic         done
);

    gb_state_t    state;
    logic [N-1:0] remaining;
    logic         down_q;
    logic         done_q;

    logic         accept;
    logic         handshake;
    logic         at_last;
    logic         core_en;
    logic [N-1:0] start_bin;
    logic [N-1:0] core_g;

    // Ready depends only on registered state and reset, never on cmd_valid.
    assign cmd_ready = (state == IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;

    assign at_last   = (remaining == '0);
    assign handshake = (state == RUN) && g_ready;

    // Only a non-final handshake advances the counter; the final code stays
    // on g_code after the burst ends.
    assign core_en   = handshake && !at_last;

    assign start_bin = N'(gray2bin(gray_word_t'(cmd_start)));

    gray_core #(
        .N (N)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (start_bin),
        .en       (core_en),
        .down     (down_q),
        .g        (core_g)
    );

    // Burst FSM with remaining-count, latched direction and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            down_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: done defaults low every cycle so it can only ever be a
            // single-cycle pulse, set by the one branch that ends a burst.
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        remaining <= cmd_len;
                        down_q    <= cmd_down;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (handshake && at_last) begin
                        // Final code accepted: completes even if abort is high.
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end else begin
                        if (handshake) begin
                            remaining <= remaining - N'(1);
                        end
                        if (abort) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign g_valid = (state == RUN);
    assign busy    = (state == RUN);
    assign g_last  = (state == RUN) && at_last;
    assign g_code  = core_g;
    assign done    = done_q;

endmodule

// File: tb/tb_gray_burst_ctrl.sv
// Directed bench for gray_burst_ctrl at N=4: table-driven bursts plus
// hand-written sequences for backpressure, abort and reset corner cases.
// Inputs are driven and outputs sampled on the falling edge.
module tb_gray_burst_ctrl;

    localparam int N = 4;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [N-1:0] cmd_start = '0;
    logic [N-1:0] cmd_len   = '0;
    logic         cmd_down  = 1'b0;
    logic         abort     = 1'b0;
    logic         g_ready   = 1'b0;
    logic         cmd_ready;
    logic         g_valid;
    logic [N-1:0] g_code;
    logic         g_last;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  start;
        logic [3:0]  len;
        logic        down;
        logic [15:0] codes;   // expected codes, first code in the top nibble
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    gray_burst_ctrl #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_len   (cmd_len),
        .cmd_down  (cmd_down),
        .abort     (abort),
        .g_valid   (g_valid),
        .g_ready   (g_ready),
        .g_code    (g_code),
        .g_last    (g_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] ref_gray(input logic [3:0] b);
        return b ^ {1'b0, b[3:1]};
    endfunction

    // Called at a falling edge in a cycle where the controller should be idle.
    task automatic send_cmd(input logic [3:0] start, input logic [3:0] len, input logic down);
        check("cmd_ready before accept", cmd_ready, 1'b1);
        cmd_start = start;
        cmd_len   = len;
        cmd_down  = down;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag, input logic exp_ready);
        check({tag, " cmd_ready"}, cmd_ready, exp_ready);
        check({tag, " g_valid"},   g_valid,   1'b0);
        check({tag, " g_code"},    g_code,    4'b0000);
        check({tag, " g_last"},    g_last,    1'b0);
        check({tag, " busy"},      busy,      1'b0);
        check({tag, " done"},      done,      1'b0);
    endtask

    // Full-throughput burst from the table; ends in the done cycle.
    task automatic run_vec(input int idx, input vec_t v);
        logic [3:0] exp;
        send_cmd(v.start, v.len, v.down);
        for (int i = 0; i <= int'(v.len); i++) begin
            exp = v.codes[15 - 4*i -: 4];
            check($sformatf("vec%0d g_valid[%0d]", idx, i), g_valid, 1'b1);
            check($sformatf("vec%0d g_code[%0d]", idx, i), g_code, exp);
            check($sformatf("vec%0d g_last[%0d]", idx, i), g_last, (i == int'(v.len)));
            @(negedge clk);
        end
        check($sformatf("vec%0d done", idx), done, 1'b1);
        check($sformatf("vec%0d cmd_ready after", idx), cmd_ready, 1'b1);
        check($sformatf("vec%0d g_valid after", idx), g_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  codes [16];
        logic [3:0]  exp;
        logic [3:0]  prev;
        logic        stalled;
        int          got;
        int          bad;
        int unsigned r;

        vecs[0] = '{4'b0000, 4'd3, 1'b0, {4'b0000, 4'b0001, 4'b0011, 4'b0010}};
        vecs[1] = '{4'b1000, 4'd1, 1'b0, {4'b1000, 4'b0000, 8'h00}};
        vecs[2] = '{4'b0000, 4'd2, 1'b1, {4'b0000, 4'b1000, 4'b1001, 4'b0000}};
        vecs[3] = '{4'b0110, 4'd3, 1'b1, {4'b0110, 4'b0010, 4'b0011, 4'b0001}};
        vecs[4] = '{4'b1111, 4'd2, 1'b0, {4'b1111, 4'b1110, 4'b1010, 4'b0000}};
        vecs[5] = '{4'b0101, 4'd0, 1'b0, {4'b0101, 12'h000}};

        // Reset values while rst is held, then ready once released.
        repeat (2) @(negedge clk);
        check_reset_outputs("reset", 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready after reset", cmd_ready, 1'b1);

        // Back-to-back table bursts at full throughput (one bubble each).
        g_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            run_vec(v, vecs[v]);
        end
        @(negedge clk);
        check("done is a single pulse", done, 1'b0);

        // Full sweep, counting down from 1100 (bin 8) through the wrap.
        send_cmd(4'b1100, 4'd15, 1'b1);
        for (int i = 0; i < 16; i++) begin
            exp = ref_gray(4'((8 - i) & 15));
            codes[i] = g_code;
            check($sformatf("sweep g_code[%0d]", i), g_code, exp);
            check($sformatf("sweep g_last[%0d]", i), g_last, (i == 15));
            @(negedge clk);
        end
        check("sweep done", done, 1'b1);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            for (int j = i + 1; j < 16; j++) begin
                if (codes[i] == codes[j]) bad++;
            end
        end
        check("sweep duplicate codes", bad, 0);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if ($countones(codes[i] ^ codes[(i + 1) % 16]) != 1) bad++;
        end
        check("sweep non-unit-distance steps", bad, 0);

        // Backpressure: g_ready low for 3 cycles on the second code.
        send_cmd(4'b0000, 4'd3, 1'b0);
        check("bp code0", g_code, 4'b0000);
        @(negedge clk);
        g_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp hold code[%0d]", i), g_code, 4'b0001);
            check($sformatf("bp hold last[%0d]", i), g_last, 1'b0);
            check($sformatf("bp hold valid[%0d]", i), g_valid, 1'b1);
            @(negedge clk);
        end
        g_ready = 1'b1;
        check("bp code1", g_code, 4'b0001);
        @(negedge clk);
        check("bp code2", g_code, 4'b0011);
        @(negedge clk);
        check("bp code3", g_code, 4'b0010);
        check("bp last", g_last, 1'b1);
        @(negedge clk);
        check("bp done", done, 1'b1);

        // Random backpressure: accepted stream must equal the full-rate stream.
        send_cmd(4'b0101, 4'd15, 1'b0);
        got = 0;
        stalled = 1'b0;
        prev = '0;
        for (int c = 0; c < 400 && got < 16; c++) begin
            if (g_valid) begin
                if (stalled) check("rand held code", g_code, prev);
                r = $urandom_range(0, 1);
                g_ready = r[0];
                if (r[0]) begin
                    check($sformatf("rand code[%0d]", got), g_code, ref_gray(4'((6 + got) & 15)));
                    check($sformatf("rand last[%0d]", got), g_last, (got == 15));
                    got++;
                end
                stalled = !r[0];
                prev = g_code;
            end
            @(negedge clk);
        end
        check("rand codes accepted", got, 16);
        check("rand done", done, 1'b1);
        g_ready = 1'b1;

        // Abort on the third code of an 8-code burst: no done.
        send_cmd(4'b0000, 4'd7, 1'b0);
        check("abort code0", g_code, 4'b0000);
        @(negedge clk);
        check("abort code1", g_code, 4'b0001);
        @(negedge clk);
        check("abort code2", g_code, 4'b0011);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort g_valid", g_valid, 1'b0);
        check("abort busy", busy, 1'b0);
        check("abort cmd_ready", cmd_ready, 1'b1);
        check("abort done", done, 1'b0);
        @(negedge clk);
        check("abort done later", done, 1'b0);

        // Abort coinciding with the final handshake: burst completes.
        send_cmd(4'b0000, 4'd1, 1'b0);
        @(negedge clk);
        check("abort-last g_last", g_last, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        check("abort-last done", done, 1'b1);
        check("abort-last g_valid", g_valid, 1'b0);

        // Abort in IDLE with a command present: the command is accepted.
        send_cmd(4'b0011, 4'd0, 1'b0);
        abort = 1'b0;
        check("idle-abort g_valid", g_valid, 1'b1);
        check("idle-abort g_code", g_code, 4'b0011);
        check("idle-abort g_last", g_last, 1'b1);
        @(negedge clk);
        check("idle-abort done", done, 1'b1);

        // Reset in the middle of a burst.
        send_cmd(4'b0000, 4'd7, 1'b0);
        repeat (2) @(negedge clk);
        check("pre-reset g_code", g_code, 4'b0011);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid-reset", 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post-reset", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_burst_ctrl.md
# gray_burst_ctrl

Command-driven sequencer for the team's parametrized Gray-code counter datapath. It accepts a burst command (start code, length, direction) over a valid/ready handshake. It then steps a Gray counter through the requested number of codes, presenting each code on a valid/ready output stream, and pulses `done` when the burst completes. It sits between a control master and any Gray-addressed consumer, such as pointer logic, a rotary/encoder model or a sequenced mux.

## Interface
Parameters:
- `N`, default 5: Gray code width; codes wrap modulo 2^N.

Ports:
- `clk`  in  1  sole clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  controller can accept a command
- `cmd_start`  in  N  first Gray code of the burst
- `cmd_len`  in  N  number of codes minus 1 (0 → 1 code, 2^N−1 → 2^N codes)
- `cmd_down`  in  1  0 = count up, 1 = count down (binary sense)
- `abort`  in  1  terminate the running burst
- `g_valid`  out  1  `g_code` is valid
- `g_ready`  in  1  consumer accepts `g_code`
- `g_code`  out  N  current Gray code
- `g_last`  out  1  `g_code` is the final code of the burst
- `busy`  out  1  burst in progress
- `done`  out  1  one-cycle pulse after the final code is accepted

## Operation
- FSM states: IDLE, RUN.
- IDLE:
  - `cmd_ready` = 1 (0 while `rst` is high).
  - On `cmd_valid && cmd_ready`, latch the binary equivalent of `cmd_start` (gray2bin: prefix XOR from MSB), `cmd_len` into the remaining count, and `cmd_down`. Go to RUN.
- RUN:
  - `g_valid` = 1, `busy` = 1, `cmd_ready` = 0.
  - `g_code` = bin ^ (bin >> 1).
  - `g_last` = (remaining == 0).
- Output handshake (`g_valid && g_ready`):
  - Not last: bin ± 1 (mod 2^N, so exactly one bit of `g_code` changes); remaining − 1.
  - Last: go to IDLE and pulse `done` in the following cycle.
- Without `g_ready`, `g_code`, `g_last` and `g_valid` hold stable. No code is skipped or repeated.
- Abort:
  - `abort` in RUN with no final handshake that cycle: go to IDLE, no `done`. A non-final handshake in that same cycle counts as consumed.
  - `abort` together with the final handshake: the burst completes normally and `done` pulses.
  - `abort` in IDLE is ignored. A simultaneous `cmd_valid` is accepted.
- Wrap-around: counting up past all-ones binary goes to 0; counting down past 0 goes to all-ones. Full-length bursts (`cmd_len` = 2^N−1) visit every code exactly once.
- `cmd_*` inputs are ignored in RUN. The master must hold them until accepted.

## Timing
- Reset values: state IDLE, `g_valid` 0, `g_code` 0, `g_last` 0, `busy` 0, `done` 0, `cmd_ready` 0 during `rst`, then 1.
- Command accepted at edge k → `g_valid` = 1 with `g_code` = `cmd_start` from cycle k+1.
- One code per cycle at full throughput (`g_ready` held high): a burst of L+1 codes occupies cycles k+1..k+L+1.
- Final handshake at edge m → `done` = 1 and `cmd_ready` = 1 during cycle m+1. A new command can be accepted at edge m+1, giving one idle bubble between bursts.
- All outputs are registered or decoded from registered state only. There is no combinational path from `g_ready` or `cmd_valid` to any output.
- Reset mid-burst: the next cycle shows reset values and no `done`.

## Structure
- Package `gray_pkg`:
  - state enum `gb_state_t` {IDLE, RUN}.
  - functions `bin2gray` and `gray2bin`, parametrized by width.
- Sub-module `gray_core`: binary register with `load`/`load_val`/`en`/`down` inputs and a Gray output `g`, reset to 0. `gray_burst_ctrl` holds the FSM, length counter and handshakes around it.

## Test plan
All scenarios use N=4.
- Up burst: `cmd_start`=0000, `cmd_len`=3, up, `g_ready`=1 → codes 0000, 0001, 0011, 0010 on consecutive cycles, `g_last` on 0010, `done` the next cycle.
- Wrap up: `cmd_start`=1000 (bin 1111), `cmd_len`=1, up → 1000, 0000.
- Down burst: `cmd_start`=0000, `cmd_len`=2, down → 0000, 1000, 1001.
- Full sweep: `cmd_len`=15 → 16 distinct codes, each adjacent pair differs in exactly one bit, including last-to-first.
- Backpressure:
  - `g_ready` low for 3 cycles on the second code → code and `g_last` held, then the sequence resumes without loss.
  - Random `g_ready` → sequence identical to the full-throughput case.
- Abort and reset:
  - `abort` on the third code of an 8-code burst → IDLE next cycle, no `done`, `cmd_ready` = 1.
  - `abort` on the final handshake → `done` pulses.
  - `rst` mid-burst → all outputs at reset values.
